dmem_responder: RTL

- Memory-side responder for the CPU data-memory port. The CPU load/store stage is the initiator; this block accepts one request at a time over a valid/ready handshake.
- Each request passes through a programmable wait-state delay. The block then performs a word-addressed read or a byte-masked write on an internal array and returns a response over a second valid/ready handshake.
- It replaces a zero-latency combinational data memory when the pipeline is exercised against realistic memory timing.

---
 rtl/dmem_pkg.sv | 35 +++
 rtl/dmem_responder_if.sv | 42 ++++
 rtl/dmem_array.sv | 34 +++
 rtl/dmem_responder.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Imported by the interface, the array and the responder top.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int WORD_BYTES  = 4;
    localparam int LATENCY_MAX = 15;
    localparam int CNT_W       = 4;

    // Keep lanes of old_w whose strobe is low, take new_w where it is high.
    function automatic logic [31:0] byte_merge(
        input logic [31:0] old_w,
        input logic [31:0] new_w,
        input logic [3:0]  strb
    );
        logic [31:0] mask;
        mask = {{8{strb[3]}}, {8{strb[2]}},
                {8{strb[1]}}, {8{strb[0]}}};
        return (new_w & mask) | (old_w & ~mask);
    endfunction

    function automatic logic addr_err(
        input logic [31:0] addr,
        input logic [31:0] depth
    );
        return (addr[1:0] != 2'b00) ||
               ({2'b00, addr[31:2]} >= depth);
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response handshake bundle between the load/store
// stage (master) and the data-memory responder (slave).
interface dmem_responder_if;

    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_write_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic [3:0]  req_wstrb_i;
    logic        resp_valid_o;
    logic        resp_ready_i;
    logic [31:0] resp_rdata_o;
    logic        resp_err_o;

    modport master (
        output req_valid_i,
        output req_write_i,
        output req_addr_i,
        output req_wdata_i,
        output req_wstrb_i,
        output resp_ready_i,
        input  req_ready_o,
        input  resp_valid_o,
        input  resp_rdata_o,
        input  resp_err_o
    );

    modport slave (
        input  req_valid_i,
        input  req_write_i,
        input  req_addr_i,
        input  req_wdata_i,
        input  req_wstrb_i,
        input  resp_ready_i,
        output req_ready_o,
        output resp_valid_o,
        output resp_rdata_o,
        output resp_err_o
    );

endinterface

// File: rtl/dmem_array.sv
// Single-port 32-bit word array, byte write enables, registered read.
// The read register only changes on an enabled read.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = 8
) (
    input  logic          i_clk,
    input  logic          i_en,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    input  logic [3:0]    i_wstrb,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_addr] <= byte_merge(r_mem[i_addr],
                                            i_wdata, i_wstrb);
            end else begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, programmable
// wait states, word read / byte-masked write, valid/ready response.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    dmem_responder_if.slave   bus
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [CNT_W-1:0] LAT_C = CNT_W'(LATENCY);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_write;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [3:0]       r_wstrb;
    logic             r_err;
    logic             r_rd_sel;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_accept;
    logic             w_commit;
    logic             w_done;

    logic             w_op_write;
    logic [31:0]      w_op_addr;
    logic [31:0]      w_op_wdata;
    logic [3:0]       w_op_wstrb;
    logic             w_op_err;
    logic [31:0]      w_arr_rdata;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_commit    = 1'b0;
        w_done      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.req_valid_i) begin
                    w_accept = 1'b1;
                    if (LATENCY == 0) begin
                        w_state_nxt = RESP;
                        w_commit    = 1'b1;
                    end else begin
                        w_state_nxt = WAIT;
                        w_cnt_nxt   = LAT_C;
                    end
                end
            end
            WAIT: begin
                w_cnt_nxt = r_cnt - 1'b1;
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = RESP;
                    w_commit    = 1'b1;
                end
            end
            RESP: begin
                if (bus.resp_ready_i) begin
                    w_state_nxt = IDLE;
                    w_done      = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Zero-latency commits happen on the acceptance edge, so the
    // operation comes straight from the bus while still in IDLE.
    always_comb begin
        w_op_write = r_write;
        w_op_addr  = r_addr;
        w_op_wdata = r_wdata;
        w_op_wstrb = r_wstrb;
        if (r_state == IDLE) begin
            w_op_write = bus.req_write_i;
            w_op_addr  = bus.req_addr_i;
            w_op_wdata = bus.req_wdata_i;
            w_op_wstrb = bus.req_wstrb_i;
        end
        w_op_err = addr_err(w_op_addr, 32'(DEPTH_WORDS));
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_write  <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
            r_err    <= 1'b0;
            r_rd_sel <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_write <= bus.req_write_i;
                r_addr  <= bus.req_addr_i;
                r_wdata <= bus.req_wdata_i;
                r_wstrb <= bus.req_wstrb_i;
            end
            if (w_commit) begin
                r_err    <= w_op_err;
                r_rd_sel <= !w_op_write && !w_op_err;
            end else if (w_done) begin
                r_err    <= 1'b0;
                r_rd_sel <= 1'b0;
            end
        end
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .i_clk   (clk_i),
        .i_en    (w_commit && !w_op_err),
        .i_we    (w_op_write),
        .i_addr  (w_op_addr[AW+1:2]),
        .i_wdata (w_op_wdata),
        .i_wstrb (w_op_wstrb),
        .o_rdata (w_arr_rdata)
    );

    // Read data is gated so stores, errors and idle show zero.
    assign bus.req_ready_o  = (r_state == IDLE);
    assign bus.resp_valid_o = (r_state == RESP);
    assign bus.resp_rdata_o = r_rd_sel ? w_arr_rdata : 32'h0;
    assign bus.resp_err_o   = r_err;

endmodule
